// File: rtl/expon_poly_fx_if.sv
// ---------------------------------------------------------------------------
// expon_poly_fx_if
// Handshake bundle for the fixed-point e^x evaluator.
//   start   : request, sampled only while the evaluator is idle
//   x_in    : signed Q(W-FRAC).FRAC argument, latched on acceptance
//   busy    : evaluation in flight
//   done    : one-cycle completion pulse
//   exp_out : signed Q(W-FRAC).FRAC result, held until the next completion
//   ovf     : saturation occurred in the last evaluation, held with exp_out
// master drives the request side, slave is the evaluator.
// ---------------------------------------------------------------------------
interface expon_poly_fx_if #(
    parameter int W = 32
);
    logic                start;
    logic signed [W-1:0] x_in;
    logic                busy;
    logic                done;
    logic signed [W-1:0] exp_out;
    logic                ovf;

    modport master (
        output start, x_in,
        input  busy, done, exp_out, ovf
    );

    modport slave (
        input  start, x_in,
        output busy, done, exp_out, ovf
    );
endinterface

// File: rtl/expon_poly_fx.sv
// ---------------------------------------------------------------------------
// expon_poly_fx
// Fixed-point e^x by Horner evaluation of the truncated Taylor series,
// one shared W x W multiplier, two cycles per term.
//   clk : rising-edge clock
//   res : asynchronous active-low reset
//   bus : expon_poly_fx_if slave (start/x_in in, busy/done/exp_out/ovf out)
// Latency from the accepting edge to done is 2*(N_TERMS-1) cycles.
// ---------------------------------------------------------------------------
module expon_poly_fx #(
    parameter int W       = 32,
    parameter int FRAC    = 24,
    parameter int N_TERMS = 8
) (
    input logic             clk,
    input logic             res,
    expon_poly_fx_if.slave  bus
);
    localparam int KW    = $clog2(N_TERMS);
    localparam int TAB_N = 1 << KW;

    localparam logic signed [W-1:0]   ONE   = W'(longint'(1) <<< FRAC);
    localparam logic signed [W-1:0]   MAXV  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] ONE2  = {{W{1'b0}}, ONE};
    localparam logic signed [2*W-1:0] MAXV2 = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] MINV2 = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

    // Reciprocal 1/k in Q.FRAC, rounded to nearest; evaluated only at
    // elaboration so no divider is built.
    function automatic logic signed [W-1:0] r_coef(input int k);
        longint num;
        if (k == 0) return '0;
        num = (longint'(1) <<< FRAC) + longint'(k / 2);
        return W'(num / longint'(k));
    endfunction

    // Clamp a shifted product into the signed W-bit range; MSB flags a clamp.
    function automatic logic [W:0] sat_p(input logic signed [2*W-1:0] v);
        if (v > MAXV2) return {1'b1, MAXV};
        if (v < MINV2) return {1'b1, 1'b1, {(W-1){1'b0}}};
        return {1'b0, v[W-1:0]};
    endfunction

    // Accumulator is a value of e^x, so it never goes below zero.
    function automatic logic [W:0] sat_acc(input logic signed [2*W-1:0] v);
        if (v < 0)     return {1'b1, {W{1'b0}}};
        if (v > MAXV2) return {1'b1, MAXV};
        return {1'b0, v[W-1:0]};
    endfunction

    logic signed [W-1:0] r_tab [TAB_N];

    for (genvar g = 0; g < TAB_N; g++) begin : g_rtab
        assign r_tab[g] = r_coef(g);
    end

    state_t              state_q;
    logic signed [W-1:0] x_q;
    logic signed [W-1:0] p_q;
    logic signed [W-1:0] acc_q;
    logic [KW-1:0]       k_q;
    logic                sticky_q;
    logic                busy_q;
    logic                done_q;
    logic signed [W-1:0] exp_q;
    logic                ovf_q;

    logic signed [W-1:0]   op_a;
    logic signed [W-1:0]   op_b;
    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;
    logic signed [2*W-1:0] prod_sh;
    logic signed [2*W-1:0] sum_d;
    logic signed [W-1:0]   p_d;
    logic signed [W-1:0]   acc_d;
    logic                  p_ovf;
    logic                  acc_ovf;

    // One multiplier: x*acc in MUL, p*R[k] in ACC.
    always_comb begin
        op_a = p_q;
        op_b = r_tab[k_q];
        if (state_q == MUL) begin
            op_a = x_q;
            op_b = acc_q;
        end
    end

    assign a_ext   = {{W{op_a[W-1]}}, op_a};
    assign b_ext   = {{W{op_b[W-1]}}, op_b};
    assign prod_sh = (a_ext * b_ext) >>> FRAC;
    assign sum_d   = ONE2 + prod_sh;

    assign {p_ovf, p_d}     = sat_p(prod_sh);
    assign {acc_ovf, acc_d} = sat_acc(sum_d);

    // Control and result registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            k_q      <= '0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            exp_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q    <= ONE;
                        k_q      <= KW'(N_TERMS - 1);
                        sticky_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    if (p_ovf) sticky_q <= 1'b1;
                    state_q <= ACC;
                end
                ACC: begin
                    acc_q    <= acc_d;
                    sticky_q <= sticky_q | acc_ovf;
                    if (k_q == KW'(1)) begin
                        exp_q   <= acc_d;
                        ovf_q   <= sticky_q | acc_ovf;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        k_q     <= k_q - KW'(1);
                        state_q <= MUL;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath operands need no reset: they are always written before use.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.start) x_q <= bus.x_in;
        if (state_q == MUL)               p_q <= p_d;
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.exp_out = exp_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_expon_poly_fx.sv
module tb_expon_poly_fx;
    localparam int W       = 32;
    localparam int FRAC    = 24;
    localparam int N_TERMS = 8;
    localparam int LAT     = 2 * (N_TERMS - 1);

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    expon_poly_fx_if #(.W(W)) bus ();

    expon_poly_fx #(.W(W), .FRAC(FRAC), .N_TERMS(N_TERMS)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic signed [W-1:0] x;
        logic [W-1:0]        e;
        int                  tol;
        bit                  o;
        string               name;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint exp,
                             input int tol);
        longint d;
        n_vec++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h +/- %0d", name, act, exp, tol);
        end
    endtask

    // Truncated Taylor series in Horner form, straight from the recurrence.
    function automatic void model(input longint x, output longint r, output bit o);
        longint one, maxv, minv, acc, p, rk;
        one  = longint'(1) << FRAC;
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -(longint'(1) << (W - 1));
        acc  = one;
        o    = 1'b0;
        for (int k = N_TERMS - 1; k >= 1; k--) begin
            rk = (one + longint'(k / 2)) / longint'(k);
            p  = (x * acc) >>> FRAC;
            if (p > maxv) begin p = maxv; o = 1'b1; end
            else if (p < minv) begin p = minv; o = 1'b1; end
            acc = one + ((p * rk) >>> FRAC);
            if (acc < 0) begin acc = 0; o = 1'b1; end
            else if (acc > maxv) begin acc = maxv; o = 1'b1; end
        end
        r = acc;
    endfunction

    // Issue one request and follow it to completion. pulse_at > 0 raises a
    // stray start (x=0) sampled at that edge after acceptance.
    task automatic eval(input logic signed [W-1:0] x, input string name,
                        input int pulse_at, input bit tail);
        longint       m_r;
        bit           m_o;
        int           cyc, busy_bad, held_bad;
        logic [W-1:0] prev_e;
        logic         prev_o;
        model(longint'(x), m_r, m_o);
        prev_e = bus.exp_out;
        prev_o = bus.ovf;
        bus.start = 1'b1;
        bus.x_in  = x;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.x_in  = $urandom;
        check({name, "_done_clr"}, longint'(bus.done), 0);
        busy_bad = (bus.busy !== 1'b1) ? 1 : 0;
        held_bad = 0;
        cyc = -1;
        for (int i = 1; i <= LAT + 10; i++) begin
            if (i == pulse_at) begin
                bus.start = 1'b1;
                bus.x_in  = '0;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                cyc = i;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.exp_out !== prev_e || bus.ovf !== prev_o) held_bad++;
        end
        check({name, "_latency"}, longint'(cyc), longint'(LAT));
        check({name, "_busy_run"}, longint'(busy_bad), 0);
        check({name, "_held"}, longint'(held_bad), 0);
        check({name, "_busy_end"}, longint'(bus.busy), 0);
        check({name, "_exp"}, longint'(bus.exp_out), m_r);
        check({name, "_ovf"}, longint'(bus.ovf), longint'(m_o));
        if (tail) begin
            @(posedge clk);
            #1;
            check({name, "_pulse"}, longint'(bus.done), 0);
            check({name, "_hold"}, longint'(bus.exp_out), m_r);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic signed [W-1:0] rx;
        int                  dones;

        tbl[0] = '{x: 32'h00000000, e: 32'h01000000, tol: 0,  o: 1'b0, name: "zero"};
        tbl[1] = '{x: 32'h01000000, e: 32'h02B7DF7D, tol: 16, o: 1'b0, name: "one"};
        tbl[2] = '{x: 32'hFF000000, e: 32'h005E2BE3, tol: 16, o: 1'b0, name: "minus_one"};
        tbl[3] = '{x: 32'h64000000, e: 32'h7FFFFFFF, tol: 0,  o: 1'b1, name: "hundred"};
        tbl[4] = '{x: 32'h80000000, e: 32'h00000000, tol: 0,  o: 1'b1, name: "most_neg"};

        bus.start = 1'b0;
        bus.x_in  = '0;
        res       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        res = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle", longint'({bus.busy, bus.done, bus.ovf, bus.exp_out}), 0);
        end

        // Table vectors against spec constants
        for (int i = 0; i < 5; i++) begin
            eval(tbl[i].x, tbl[i].name, 0, 1'b1);
            check_tol({tbl[i].name, "_const"}, longint'(bus.exp_out), longint'(tbl[i].e),
                      tbl[i].tol);
            check({tbl[i].name, "_ovf_const"}, longint'(bus.ovf), longint'(tbl[i].o));
        end

        // Back-to-back: second start sampled while done is high
        eval(32'sh64000000, "b2b_sat", 0, 1'b0);
        check("b2b_sat_const", longint'(bus.exp_out), 64'h7FFFFFFF);
        eval(32'sh00000000, "b2b_zero", 0, 1'b1);
        check("b2b_zero_const", longint'(bus.exp_out), 64'h01000000);
        check("b2b_zero_ovf", longint'(bus.ovf), 0);

        // Start during evaluation is ignored
        eval(32'sh01000000, "ignored_start", 5, 1'b1);
        check_tol("ignored_start_const", longint'(bus.exp_out), 64'h02B7DF7D, 16);

        // Randomized arguments: half in [-1,1], half across the full range
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) rx = W'(int'($urandom_range(0, 2 ** 25)) - 2 ** 24);
            else            rx = $urandom;
            eval(rx, "rand", 0, (i % 3 == 0));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // Reset in the middle of an evaluation
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = 32'sh01000000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 5) begin
                bus.start = 1'b1;
                bus.x_in  = '0;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) dones++;
        end
        res = 1'b0;
        #1;
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_exp", longint'(bus.exp_out), 0);
        check("rst_ovf", longint'(bus.ovf), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        res = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        check("rst_no_done", longint'(dones), 0);
        check("rst_exp_idle", longint'(bus.exp_out), 0);
        eval(32'sh00000000, "after_rst", 0, 1'b1);
        check("after_rst_const", longint'(bus.exp_out), 64'h01000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
